// File: rtl/quad_pkg.sv
// Shared phase types and transition helpers for the quadrature decoder.
// Phase is {A,B}; the up direction walks 00->10->11->01->00.
package quad_pkg;

  typedef logic [1:0] phase_t;

  localparam phase_t PH_00 = 2'b00;
  localparam phase_t PH_10 = 2'b10;
  localparam phase_t PH_11 = 2'b11;
  localparam phase_t PH_01 = 2'b01;

  typedef enum logic [1:0] {
    TR_NONE,
    TR_UP,
    TR_DOWN,
    TR_BAD
  } trans_e;

  function automatic phase_t next_up(phase_t p);
    phase_t n;
    case (p)
      PH_00:   n = PH_10;
      PH_10:   n = PH_11;
      PH_11:   n = PH_01;
      default: n = PH_00;
    endcase
    return n;
  endfunction

  function automatic trans_e decode(phase_t prev, phase_t cur);
    trans_e t;
    if (cur == prev)
      t = TR_NONE;
    else if (cur == next_up(prev))
      t = TR_UP;
    else if (prev == next_up(cur))
      t = TR_DOWN;
    else
      t = TR_BAD;
    return t;
  endfunction

  // Which valid transitions are counted at a given resolution.
  function automatic logic res_gate(int res, phase_t prev,
                                    phase_t cur);
    logic g;
    case (res)
      4:       g = 1'b1;
      2:       g = prev[1] ^ cur[1];
      default: g = ~prev[1] & cur[1];
    endcase
    return g;
  endfunction

endpackage

// File: rtl/glitch_filter.sv
// One encoder channel: synchroniser, persistence filter and
// priming bypass that loads the synced level directly.
module glitch_filter #(
  parameter int SyncStages = 2,
  parameter int FilterLen  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic prime_i,
  input  logic raw_i,
  output logic sync_o,
  output logic filt_o
);

  localparam int CW = $clog2(FilterLen + 1);
  localparam logic [CW-1:0] LastCnt = CW'(FilterLen - 1);

  if (SyncStages < 2 || SyncStages > 3) begin : g_bad_sync
    $error("glitch_filter: SyncStages must be 2..3");
  end
  if (FilterLen < 1 || FilterLen > 16) begin : g_bad_len
    $error("glitch_filter: FilterLen must be 1..16");
  end

  logic [SyncStages-1:0] sync_q;
  logic                  filt_q, filt_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  assign sync_o = sync_q[SyncStages-1];
  assign filt_o = filt_q;

  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (prime_i) begin
      filt_d = sync_o;
    end else if (sync_o != filt_q) begin
      if (cnt_q == LastCnt)
        filt_d = sync_o;
      else
        cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], raw_i};
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature encoder front end: filtered A/B phase decode into a
// step pulse, direction level and saturating illegal-edge count.
module quadrature_decoder
  import quad_pkg::*;
#(
  parameter int SyncStages = 2,
  parameter int FilterLen  = 4,
  parameter int Resolution = 4,
  parameter int ErrWidth   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                encA,
  input  logic                encB,
  input  logic                enable,
  input  logic                clearErr,
  output logic                step,
  output logic                upDown,
  output logic                illegal,
  output logic [ErrWidth-1:0] errCount
);

  localparam int PrimeLen = SyncStages + FilterLen;
  localparam int PW = $clog2(PrimeLen + 1);
  localparam logic [PW-1:0] PrimeEnd = PW'(PrimeLen);

  if (Resolution != 1 && Resolution != 2
      && Resolution != 4) begin : g_bad_res
    $error("quadrature_decoder: Resolution must be 1, 2 or 4");
  end
  if (ErrWidth < 1) begin : g_bad_ew
    $error("quadrature_decoder: ErrWidth must be >= 1");
  end

  logic   sync_a, sync_b;
  logic   filt_a, filt_b;
  phase_t sync_ph, filt_ph;
  trans_e tr;
  logic   priming;

  logic [PW-1:0]       prime_q, prime_d;
  phase_t              prev_q, prev_d;
  logic                step_q, step_d;
  logic                up_q, up_d;
  logic                ill_q, ill_d;
  logic [ErrWidth-1:0] err_q, err_d;

  glitch_filter #(
    .SyncStages(SyncStages),
    .FilterLen (FilterLen)
  ) u_filt_a (
    .clk    (clk),
    .rst    (rst),
    .prime_i(priming),
    .raw_i  (encA),
    .sync_o (sync_a),
    .filt_o (filt_a)
  );

  glitch_filter #(
    .SyncStages(SyncStages),
    .FilterLen (FilterLen)
  ) u_filt_b (
    .clk    (clk),
    .rst    (rst),
    .prime_i(priming),
    .raw_i  (encB),
    .sync_o (sync_b),
    .filt_o (filt_b)
  );

  assign sync_ph = {sync_a, sync_b};
  assign filt_ph = {filt_a, filt_b};
  assign priming = (prime_q != PrimeEnd);
  assign tr      = decode(prev_q, filt_ph);

  always_comb begin
    prime_d = priming ? prime_q + 1'b1 : prime_q;
    prev_d  = priming ? sync_ph : filt_ph;
    step_d  = 1'b0;
    ill_d   = 1'b0;
    up_d    = up_q;
    err_d   = err_q;
    if (!priming) begin
      unique case (tr)
        TR_UP: begin
          up_d   = 1'b1;
          step_d = enable
                 & res_gate(Resolution, prev_q, filt_ph);
        end
        TR_DOWN: begin
          up_d   = 1'b0;
          step_d = enable
                 & res_gate(Resolution, prev_q, filt_ph);
        end
        TR_BAD:  ill_d = enable;
        default: ;
      endcase
    end
    // Clear takes priority over a coincident illegal edge.
    if (clearErr)
      err_d = '0;
    else if (ill_d && !(&err_q))
      err_d = err_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prime_q <= '0;
      prev_q  <= PH_00;
      step_q  <= 1'b0;
      up_q    <= 1'b0;
      ill_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      prime_q <= prime_d;
      prev_q  <= prev_d;
      step_q  <= step_d;
      up_q    <= up_d;
      ill_q   <= ill_d;
      err_q   <= err_d;
    end
  end

  assign step     = step_q;
  assign upDown   = up_q;
  assign illegal  = ill_q;
  assign errCount = err_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Directed bench for quadrature_decoder at default settings
// plus a Resolution=1 copy sharing the same encoder stimulus.
module tb_quadrature_decoder;

  logic       clk;
  logic       rst;
  logic       encA, encB;
  logic       enable, clearErr;
  logic       step0, upDown0, illegal0;
  logic [7:0] errCount0;
  logic       step1, upDown1, illegal1;
  logic [7:0] errCount1;

  int n_checks = 0;
  int n_fail   = 0;
  int s0, s1, il, il1, f0, cyc;

  quadrature_decoder dut0 (
    .clk     (clk),
    .rst     (rst),
    .encA    (encA),
    .encB    (encB),
    .enable  (enable),
    .clearErr(clearErr),
    .step    (step0),
    .upDown  (upDown0),
    .illegal (illegal0),
    .errCount(errCount0)
  );

  quadrature_decoder #(.Resolution(1)) dut1 (
    .clk     (clk),
    .rst     (rst),
    .encA    (encA),
    .encB    (encB),
    .enable  (enable),
    .clearErr(clearErr),
    .step    (step1),
    .upDown  (upDown1),
    .illegal (illegal1),
    .errCount(errCount1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic clr();
    s0 = 0; s1 = 0; il = 0; il1 = 0; f0 = 0; cyc = 0;
  endtask

  task automatic setph(input logic a, input logic b);
    encA = a;
    encB = b;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (step0 === 1'b1) begin
        s0++;
        if (f0 == 0) f0 = cyc;
      end
      if (step1 === 1'b1) s1++;
      if (illegal0 === 1'b1) il++;
      if (illegal1 === 1'b1) il1++;
    end
  endtask

  initial begin
    rst = 1'b0; encA = 1'b0; encB = 1'b0;
    enable = 1'b1; clearErr = 1'b0;
    clr();
    run(3);
    check("rst_step", step0, 0);
    check("rst_updown", upDown0, 0);
    check("rst_illegal", illegal0, 0);
    check("rst_err", errCount0, 0);

    rst = 1'b1;
    clr();
    run(12);
    check("prime_nostep", s0, 0);
    check("prime_noill", il, 0);

    // Up sequence, one step each, 7 cycles after the edge.
    s1 = 0;
    begin
      logic [1:0] up_seq [4];
      int tot1;
      up_seq[0] = 2'b10; up_seq[1] = 2'b11;
      up_seq[2] = 2'b01; up_seq[3] = 2'b00;
      tot1 = 0;
      for (int k = 0; k < 4; k++) begin
        clr();
        setph(up_seq[k][1], up_seq[k][0]);
        run(10);
        check("up_steps", s0, 1);
        check("up_latency", f0, 7);
        tot1 += s1;
      end
      check("up_dir", upDown0, 1);
      check("res1_up_steps", tot1, 1);
      check("res1_up_dir", upDown1, 1);
    end

    begin
      logic [1:0] dn_seq [4];
      int tot1;
      dn_seq[0] = 2'b01; dn_seq[1] = 2'b11;
      dn_seq[2] = 2'b10; dn_seq[3] = 2'b00;
      tot1 = 0;
      for (int k = 0; k < 4; k++) begin
        clr();
        setph(dn_seq[k][1], dn_seq[k][0]);
        run(10);
        check("dn_steps", s0, 1);
        tot1 += s1;
      end
      check("dn_dir", upDown0, 0);
      check("res1_dn_steps", tot1, 1);
      check("res1_dn_dir", upDown1, 0);
    end

    // Glitch shorter than the filter length is dropped.
    clr();
    encA = 1'b1;
    run(3);
    encA = 1'b0;
    run(10);
    check("glitch_steps", s0, 0);
    check("glitch_ill", il, 0);
    check("glitch_filtA", dut0.u_filt_a.filt_o, 0);

    // Exactly FilterLen cycles is accepted: up then back down.
    clr();
    encA = 1'b1;
    run(4);
    encA = 1'b0;
    run(12);
    check("pulse4_steps", s0, 2);
    check("pulse4_res1", s1, 1);
    check("pulse4_dir", upDown0, 0);

    // Both channels at once.
    clr();
    setph(1'b1, 1'b1);
    run(10);
    check("ill_pulse", il, 1);
    check("ill_nostep", s0, 0);
    check("ill_err1", errCount0, 1);
    check("ill_dir", upDown0, 0);

    clr();
    for (int k = 0; k < 300; k++) begin
      setph(k[0] ? 1'b1 : 1'b0, k[0] ? 1'b1 : 1'b0);
      run(6);
    end
    run(10);
    check("sat_ill_count", il, 300);
    check("sat_nostep", s0, 0);
    check("sat_err", errCount0, 255);
    check("sat_err_res1", errCount1, 255);

    // clearErr landing on the same cycle as an illegal edge.
    clr();
    setph(1'b0, 1'b0);
    run(6);
    clearErr = 1'b1;
    run(1);
    check("clr_ill_pulse", illegal0, 1);
    check("clr_err", errCount0, 0);
    clearErr = 1'b0;
    run(5);
    check("clr_err_hold", errCount0, 0);

    // Disabled: direction tracks, no steps, no burst after.
    check("dis_dir_before", upDown0, 0);
    enable = 1'b0;
    clr();
    setph(1'b1, 1'b0); run(10);
    setph(1'b1, 1'b1); run(10);
    setph(1'b0, 1'b1); run(10);
    check("dis_steps", s0, 0);
    check("dis_res1", s1, 0);
    check("dis_dir", upDown0, 1);
    enable = 1'b1;
    clr();
    run(10);
    check("reen_steps", s0, 0);
    check("reen_ill", il, 0);
    clr();
    setph(1'b0, 1'b0);
    run(10);
    check("reen_next_step", s0, 1);
    check("reen_latency", f0, 7);

    // Park at 11 via an illegal edge, then reset.
    clr();
    setph(1'b1, 1'b1);
    run(10);
    check("park_ill", il, 1);
    check("park_err", errCount0, 1);
    check("park_dir", upDown0, 1);
    rst = 1'b0;
    #1;
    check("arst_dir", upDown0, 0);
    check("arst_err", errCount0, 0);
    run(4);
    check("rstlo_step", step0, 0);
    check("rstlo_ill", illegal0, 0);
    check("rstlo_dir", upDown0, 0);
    rst = 1'b1;
    clr();
    run(20);
    check("rel_steps", s0, 0);
    check("rel_ill", il, 0);
    check("rel_err", errCount0, 0);
    clr();
    setph(1'b0, 1'b1);
    run(10);
    check("post_steps", s0, 1);
    check("post_latency", f0, 7);
    check("post_dir", upDown0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
